// File: rtl/reg_scoreboard.sv
// Register write scoreboard.
// Tracks in-flight register writes between issue (D->E) and writeback. Each
// register has an in-flight write count and a countdown of cycles until its
// youngest result can be forwarded. The block raises the decode-stage stall for
// hazards the bypass network cannot cover: load-use, multi-cycle MDU results,
// and saturation of the per-register in-flight counter.
module reg_scoreboard #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MDU_LAT  = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        rs_useD,
    input  logic        rt_useD,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [4:0]  issue_rd,
    input  logic [1:0]  issue_kind,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        stallD,
    output logic [31:0] busy_mask,
    output logic [31:0] stall_cycles,
    output logic        err_underflow
);

    localparam logic [CNT_W-1:0] LoadLatC = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] MduLatC  = CNT_W'(MDU_LAT);

    localparam logic [1:0] KindAlu  = 2'b00;
    localparam logic [1:0] KindLoad = 2'b01;

    // Per-register state; entry 0 exists only for uniform indexing and stays zero.
    logic [1:0]       r_inflight  [32];
    logic [CNT_W-1:0] r_ready_cnt [32];
    logic [31:0]      r_stall_cycles;
    logic             r_err_underflow;

    logic [1:0]       w_inflight_d  [32];
    logic [CNT_W-1:0] w_ready_cnt_d [32];
    logic [31:0]      w_stall_cycles_d;
    logic             w_err_underflow_d;

    logic             w_rs_hazard;
    logic             w_rt_hazard;
    logic             w_waw_full;
    logic             w_stall;
    logic             w_accept;
    logic             w_track;
    logic             w_wb;
    logic             w_wb_underflow;
    logic [CNT_W-1:0] w_issue_lat;

    // Result latency of the issuing instruction; kind 11 is treated as MDU.
    always_comb begin
        w_issue_lat = MduLatC;
        case (issue_kind)
            KindAlu:  w_issue_lat = '0;
            KindLoad: w_issue_lat = LoadLatC;
            default:  w_issue_lat = MduLatC;
        endcase
    end

    // Hazard detection from current register state only; writeback in the same
    // cycle does not relieve a stall.
    always_comb begin
        w_rs_hazard = rs_useD && (rsD != 5'd0) && (r_ready_cnt[rsD] != '0);
        w_rt_hazard = rt_useD && (rtD != 5'd0) && (r_ready_cnt[rtD] != '0);
        w_waw_full  = issue_we && (issue_rd != 5'd0) && (r_inflight[issue_rd] == 2'd3);
        // Held low during reset so the pipeline is not frozen while state clears.
        w_stall     = rst_n && issue_valid && (w_rs_hazard || w_rt_hazard || w_waw_full);
        w_accept    = issue_valid && !w_stall;
        w_track     = w_accept && issue_we && (issue_rd != 5'd0);
        w_wb        = wb_valid && (wb_rd != 5'd0);
    end

    // Writeback to a register with nothing in flight; a same-cycle issue to the
    // same register cancels it out and is not an error.
    always_comb begin
        w_wb_underflow = w_wb && (r_inflight[wb_rd] == 2'd0)
                         && !(w_track && (issue_rd == wb_rd));
    end

    // Next-state for the per-register countdowns and in-flight counts.
    always_comb begin
        w_inflight_d[0]  = '0;
        w_ready_cnt_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            logic w_iss_hit;
            logic w_wb_hit;
            w_iss_hit = w_track && (issue_rd == 5'(r));
            w_wb_hit  = w_wb && (wb_rd == 5'(r));

            // Youngest write governs: a new issue reloads the countdown outright.
            w_ready_cnt_d[r] = r_ready_cnt[r];
            if (w_iss_hit) begin
                w_ready_cnt_d[r] = w_issue_lat;
            end else if (r_ready_cnt[r] != '0) begin
                w_ready_cnt_d[r] = r_ready_cnt[r] - 1'b1;
            end

            // Count never exceeds 3: issue to a full register is stalled.
            w_inflight_d[r] = r_inflight[r];
            case ({w_iss_hit, w_wb_hit})
                2'b10: w_inflight_d[r] = r_inflight[r] + 2'd1;
                2'b01: begin
                    if (r_inflight[r] != 2'd0) begin
                        w_inflight_d[r] = r_inflight[r] - 2'd1;
                    end
                end
                default: w_inflight_d[r] = r_inflight[r];
            endcase
        end
    end

    // Saturating stall counter and sticky underflow flag.
    always_comb begin
        w_stall_cycles_d = r_stall_cycles;
        if (w_stall && (r_stall_cycles != '1)) begin
            w_stall_cycles_d = r_stall_cycles + 32'd1;
        end
        w_err_underflow_d = r_err_underflow || w_wb_underflow;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                r_inflight[r]  <= '0;
                r_ready_cnt[r] <= '0;
            end
            r_stall_cycles  <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                r_inflight[r]  <= w_inflight_d[r];
                r_ready_cnt[r] <= w_ready_cnt_d[r];
            end
            r_stall_cycles  <= w_stall_cycles_d;
            r_err_underflow <= w_err_underflow_d;
        end
    end

    // Busy view derived directly from the registered in-flight counts.
    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < 32; r++) begin
            busy_mask[r] = (r_inflight[r] != 2'd0);
        end
    end

    assign stallD        = w_stall;
    assign stall_cycles  = r_stall_cycles;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: load-use, MDU, ALU, WAW saturation,
// underflow, r0 handling and reset mid-countdown.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        rs_useD;
    logic        rt_useD;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_kind;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stallD;
    logic [31:0] busy_mask;
    logic [31:0] stall_cycles;
    logic        err_underflow;

    int n_err;
    int n_chk;

    reg_scoreboard #(
        .LOAD_LAT (1),
        .MDU_LAT  (4),
        .CNT_W    (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rsD           (rsD),
        .rtD           (rtD),
        .rs_useD       (rs_useD),
        .rt_useD       (rt_useD),
        .issue_valid   (issue_valid),
        .issue_we      (issue_we),
        .issue_rd      (issue_rd),
        .issue_kind    (issue_kind),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .stallD        (stallD),
        .busy_mask     (busy_mask),
        .stall_cycles  (stall_cycles),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rsD = 5'd0; rtD = 5'd0; rs_useD = 1'b0; rt_useD = 1'b0;
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0; issue_kind = 2'b00;
        wb_valid = 1'b0; wb_rd = 5'd0;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        idle();
        tick();
        tick();

        // Reset: outputs idle even with a request presented
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5; issue_kind = 2'b10;
        rs_useD = 1'b1; rsD = 5'd5;
        #1;
        chk("rst_stall", 32'(stallD), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        // Load r5 then dependent read of r5: exactly one stall cycle
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5; issue_kind = 2'b01;
        #1 chk("ld_issue_stall", 32'(stallD), 32'd0);
        tick();
        issue_rd = 5'd6; issue_kind = 2'b00; rs_useD = 1'b1; rsD = 5'd5;
        #1 chk("ld_use_stall", 32'(stallD), 32'd1);
        chk("ld_busy", busy_mask, 32'h0000_0020);
        tick();
        #1 chk("ld_use_go", 32'(stallD), 32'd0);
        tick();
        idle();
        #1 chk("ld_stall_cycles", stall_cycles, 32'd1);
        chk("ld_busy2", busy_mask, 32'h0000_0060);
        wb_valid = 1'b1; wb_rd = 5'd5;
        tick();
        wb_rd = 5'd6;
        tick();
        idle();
        #1 chk("ld_busy_clear", busy_mask, 32'd0);
        tick();

        // MDU r8 then consumer via rt: four stall cycles
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd8; issue_kind = 2'b10;
        #1 chk("mdu_issue_stall", 32'(stallD), 32'd0);
        tick();
        issue_we = 1'b0; issue_rd = 5'd0; rt_useD = 1'b1; rtD = 5'd8;
        for (int k = 0; k < 4; k++) begin
            #1 chk("mdu_stall", 32'(stallD), 32'd1);
            tick();
        end
        #1 chk("mdu_go", 32'(stallD), 32'd0);
        tick();
        idle();
        #1 chk("mdu_stall_cycles", stall_cycles, 32'd5);
        chk("mdu_busy", busy_mask, 32'h0000_0100);
        wb_valid = 1'b1; wb_rd = 5'd8;
        tick();

        // Kind 11 behaves as MDU: stall at t+4, free at t+5
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd10; issue_kind = 2'b11;
        tick();
        issue_we = 1'b0; issue_rd = 5'd0; rs_useD = 1'b1; rsD = 5'd10;
        tick();
        tick();
        tick();
        #1 chk("k11_stall_t4", 32'(stallD), 32'd1);
        tick();
        #1 chk("k11_go_t5", 32'(stallD), 32'd0);
        tick();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd10;
        tick();

        // ALU r3 then immediate consumer: never stalls, busy until writeback
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd3; issue_kind = 2'b00;
        #1 chk("alu_issue_stall", 32'(stallD), 32'd0);
        tick();
        issue_we = 1'b0; issue_rd = 5'd0; rs_useD = 1'b1; rsD = 5'd3;
        #1 chk("alu_use_stall", 32'(stallD), 32'd0);
        chk("alu_busy", busy_mask, 32'h0000_0008);
        tick();
        idle();
        #1 chk("alu_busy_hold", busy_mask, 32'h0000_0008);
        wb_valid = 1'b1; wb_rd = 5'd3;
        tick();
        idle();
        #1 chk("alu_busy_clear", busy_mask, 32'd0);
        chk("pre_waw_stall_cycles", stall_cycles, 32'd9);

        // Three writes to r9 in flight, then a fourth must stall
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd9; issue_kind = 2'b00;
        tick();
        tick();
        tick();
        #1 chk("waw_full_stall", 32'(stallD), 32'd1);
        chk("waw_busy", busy_mask, 32'h0000_0200);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd9;
        #1 chk("waw_full_wb_stall", 32'(stallD), 32'd1);
        tick();
        #1 chk("waw_two_wb_issue", 32'(stallD), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1 chk("waw_still_two", 32'(stallD), 32'd0);
        tick();
        #1 chk("waw_full_again", 32'(stallD), 32'd1);
        tick();
        idle();
        #1 chk("waw_stall_cycles", stall_cycles, 32'd12);
        wb_valid = 1'b1; wb_rd = 5'd9;
        tick();
        idle();
        #1 chk("waw_first_wb_busy", busy_mask, 32'h0000_0200);
        wb_valid = 1'b1; wb_rd = 5'd9;
        tick();
        tick();
        idle();
        #1 chk("waw_drained", busy_mask, 32'd0);
        chk("waw_no_err", 32'(err_underflow), 32'd0);

        // Writeback to an untracked register sets the sticky error
        wb_valid = 1'b1; wb_rd = 5'd12;
        tick();
        idle();
        #1 chk("uf_set", 32'(err_underflow), 32'd1);
        tick();
        tick();
        #1 chk("uf_sticky", 32'(err_underflow), 32'd1);

        // r0 is never tracked
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd0; issue_kind = 2'b10;
        #1 chk("r0_issue_stall", 32'(stallD), 32'd0);
        tick();
        rs_useD = 1'b1; rsD = 5'd0; rt_useD = 1'b1; rtD = 5'd0;
        #1 chk("r0_use_stall", 32'(stallD), 32'd0);
        chk("r0_busy", busy_mask, 32'd0);
        tick();

        // Reset during an MDU countdown discards all tracking
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd8; issue_kind = 2'b10;
        tick();
        issue_we = 1'b0; issue_rd = 5'd0; rt_useD = 1'b1; rtD = 5'd8;
        #1 chk("mrst_pre_stall", 32'(stallD), 32'd1);
        rst_n = 1'b0;
        #1 chk("mrst_stall_in_rst", 32'(stallD), 32'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("mrst_stall", 32'(stallD), 32'd0);
        chk("mrst_busy", busy_mask, 32'd0);
        chk("mrst_stall_cycles", stall_cycles, 32'd0);
        chk("mrst_err", 32'(err_underflow), 32'd0);
        tick();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
